// File: rtl/harris_run_ctrl_pkg.sv
// Types and defaults shared by the HIR and HLS benchmark benches and their run sequencer.
package harris_bench_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } run_state_t;
endpackage

// File: rtl/harris_run_ctrl_if.sv
// Host streams, kernel handshake and memory ports of the benchmark run sequencer.
interface harris_run_ctrl_if #(
  parameter int WIDTH  = harris_bench_pkg::DEF_WIDTH,
  parameter int ADDR_W = harris_bench_pkg::DEF_ADDR_W,
  parameter int CNT_W  = 32
);
  logic              go;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              k_start;
  logic              k_done;
  logic              kernel_owns_mem;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [WIDTH-1:0]  imem_wr_data;
  logic              omem_rd_en;
  logic [ADDR_W-1:0] omem_rd_addr;
  logic [WIDTH-1:0]  omem_rd_data;
  logic              busy;
  logic              timeout;
  logic [CNT_W-1:0]  cycles;

  modport slave (
    input  go, len, in_valid, in_data, out_ready, k_done, omem_rd_data,
    output in_ready, out_valid, out_data, k_start, kernel_owns_mem,
           imem_wr_en, imem_wr_addr, imem_wr_data, omem_rd_en, omem_rd_addr,
           busy, timeout, cycles
  );

  modport master (
    output go, len, in_valid, in_data, out_ready, k_done, omem_rd_data,
    input  in_ready, out_valid, out_data, k_start, kernel_owns_mem,
           imem_wr_en, imem_wr_addr, imem_wr_data, omem_rd_en, omem_rd_addr,
           busy, timeout, cycles
  );
endinterface

// File: rtl/harris_run_ctrl_rd_skid_fifo.sv
// 2-entry FIFO behind a 1-cycle-latency memory read; an arriving word bypasses straight
// to the output when nothing is stored, so drain runs at one word per cycle.
module rd_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  logic [1:0][WIDTH-1:0] mem_q;
  logic                  rd_idx, wr_idx;
  logic [1:0]            cnt_q;
  logic                  stored, push, pop_s;

  assign stored    = (cnt_q != 2'd0);
  assign out_valid = stored || in_vld;
  assign out_data  = stored ? mem_q[rd_idx] : in_data;
  // arriving word is stored unless it leaves through the bypass this cycle
  assign push      = in_vld && (stored || !out_ready);
  assign pop_s     = stored && out_ready;
  assign count     = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      rd_idx <= 1'b0;
      wr_idx <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_idx] <= in_data;
        wr_idx        <= ~wr_idx;
      end
      if (pop_s) rd_idx <= ~rd_idx;
      case ({push, pop_s})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/harris_run_ctrl.sv
// Benchmark run sequencer: load image, start kernel and time it, drain result memory.
module harris_run_ctrl
  import harris_bench_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 1048576,
  parameter int CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  harris_run_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ADDR_W:0]  ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]  FULL_LEN = ONE << ADDR_W;

  run_state_t       state_q, state_d;
  logic [ADDR_W:0]  len_q, len_eff, wr_cnt, rd_cnt, pop_cnt;
  logic [CNT_W-1:0] cnt_q, cnt_inc, cycles_q;
  logic             timeout_q, rd_inflight;
  logic             wr_fire, load_last, run_hit_to, rd_issue, pop, drain_last;
  logic             in_ready_c, k_start_c, owns_c;
  logic [1:0]       fifo_cnt;
  logic             fifo_vld;
  logic [WIDTH-1:0] fifo_data;

  assign len_eff    = (bus.len == '0) ? FULL_LEN : bus.len;
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign wr_fire    = (state_q == ST_LOAD) && bus.in_valid;
  assign load_last  = wr_fire && ((wr_cnt + ONE) == len_q);
  assign run_hit_to = (cnt_inc >= TO_LIM);
  // in-flight read counts against FIFO space so a stalled output never drops data
  assign rd_issue   = (state_q == ST_DRAIN) && (rd_cnt != len_q) &&
                      (({1'b0, fifo_cnt} + {2'b00, rd_inflight}) < 3'd2);
  assign pop        = fifo_vld && bus.out_ready;
  assign drain_last = pop && ((pop_cnt + ONE) == len_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.go) state_d = ST_LOAD;
      ST_LOAD:  if (load_last) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (bus.k_done || run_hit_to) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    k_start_c  = 1'b0;
    owns_c     = 1'b0;
    case (state_q)
      ST_LOAD:  in_ready_c = 1'b1;
      ST_START: begin
        k_start_c = 1'b1;
        owns_c    = 1'b1;
      end
      ST_RUN:   owns_c = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      pop_cnt     <= '0;
      cnt_q       <= '0;
      cycles_q    <= '0;
      timeout_q   <= 1'b0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= rd_issue;
      case (state_q)
        ST_IDLE: if (bus.go) begin
          len_q     <= len_eff;
          wr_cnt    <= '0;
          rd_cnt    <= '0;
          pop_cnt   <= '0;
          cnt_q     <= '0;
          cycles_q  <= '0;
          timeout_q <= 1'b0;
        end
        ST_LOAD:  if (wr_fire) wr_cnt <= wr_cnt + ONE;
        ST_START: cnt_q <= CNT_W'(1);
        ST_RUN: begin
          cnt_q <= cnt_inc;
          // count includes the final cycle; done on the limit cycle is not a timeout
          if (bus.k_done || run_hit_to) cycles_q <= cnt_inc;
          if (!bus.k_done && run_hit_to) timeout_q <= 1'b1;
        end
        ST_DRAIN: begin
          if (rd_issue) rd_cnt  <= rd_cnt + ONE;
          if (pop)      pop_cnt <= pop_cnt + ONE;
        end
        default: ;
      endcase
    end
  end

  rd_skid_fifo #(.WIDTH(WIDTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (rd_inflight),
    .in_data   (bus.omem_rd_data),
    .out_ready (bus.out_ready),
    .out_valid (fifo_vld),
    .out_data  (fifo_data),
    .count     (fifo_cnt)
  );

  assign bus.in_ready        = in_ready_c;
  assign bus.k_start         = k_start_c;
  assign bus.kernel_owns_mem = owns_c;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.imem_wr_en      = wr_fire;
  assign bus.imem_wr_addr    = wr_cnt[ADDR_W-1:0];
  assign bus.imem_wr_data    = bus.in_data;
  assign bus.omem_rd_en      = rd_issue;
  assign bus.omem_rd_addr    = rd_cnt[ADDR_W-1:0];
  assign bus.out_valid       = fifo_vld;
  assign bus.out_data        = fifo_data;
  assign bus.timeout         = timeout_q;
  assign bus.cycles          = cycles_q;
endmodule

// File: tb/tb_harris_run_ctrl.sv
// Bench for harris_run_ctrl: vector table of whole runs, randomized runs against a
// run-level reference model, and hand sequences for reset and len=0.
module tb_harris_run_ctrl;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  harris_run_ctrl_if #(.WIDTH(32), .ADDR_W(AW), .CNT_W(32)) bus ();

  harris_run_ctrl #(.WIDTH(32), .ADDR_W(AW), .TIMEOUT(TO), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] imem_m [DEPTH];
  logic [31:0] omem_m [DEPTH];

  typedef struct {
    int len;
    int kd;       // k_done delay after k_start, -1 = never
    int vm;       // 0 continuous in_valid, 1 random
    int rm;       // 0 ready=1, 1 pattern 1,0,0, 2 random
    int exp_cyc;
    bit exp_to;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: done counts only while running, otherwise the run is cut at TO cycles
  function automatic int model_cycles(input int kd);
    return (kd >= 1 && kd + 1 <= TO) ? kd + 1 : TO;
  endfunction

  function automatic bit model_to(input int kd);
    return !(kd >= 1 && kd + 1 <= TO);
  endfunction

  task automatic run(input int len_in, input int kd, input int vm, input int rm,
                     input int exp_cyc, input bit exp_to, input bit tbl_data, input bit extra_go);
    int L;
    logic [31:0] words [$];
    int widx, rd_idx, wr_bad, rd_bad, first_wr, last_wr, ks_cnt, ks_iter, own_cnt, own_fall;
    int first_rd, first_ov, first_pop, last_pop, busy_fall, stab_bad, pops, pop_bad, img_bad;
    logic ir1, cyc1_zero, to1;
    logic pend_rd, prev_stall;
    logic [AW-1:0] pend_addr;
    logic [31:0] prev_data;
    L = (len_in == 0) ? DEPTH : len_in;
    words.delete();
    for (int i = 0; i < L; i++) words.push_back(tbl_data ? 32'hA + i : $urandom);
    for (int i = 0; i < DEPTH; i++) omem_m[i] = (tbl_data && i < L) ? i + 1 : $urandom;
    widx = 0; rd_idx = 0; wr_bad = 0; rd_bad = 0; first_wr = -1; last_wr = -1;
    ks_cnt = 0; ks_iter = -1; own_cnt = 0; own_fall = -1; first_rd = -1; first_ov = -1;
    first_pop = -1; last_pop = -1; busy_fall = -1; stab_bad = 0; pops = 0; pop_bad = 0;
    ir1 = 0; cyc1_zero = 0; to1 = 1; pend_rd = 0; pend_addr = '0; prev_stall = 0; prev_data = '0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      bus.go = (k == 0) || (extra_go && (k == 3 || (ks_iter >= 0 && k == ks_iter + 2)));
      bus.len = (k == 0) ? 11'(len_in) : 11'($urandom);
      bus.k_done = (k == 1) || (kd >= 1 && ks_iter >= 0 && k == ks_iter + kd);
      bus.omem_rd_data = pend_rd ? omem_m[pend_addr] : $urandom;
      bus.in_valid = (vm == 0) ? (widx < L) : ($urandom_range(0, 1) == 1);
      bus.in_data = (widx < L) ? words[widx] : $urandom;
      case (rm)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (k % 3 == 0);
        default: bus.out_ready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      if (k == 1) begin
        ir1 = bus.in_ready;
        cyc1_zero = (bus.cycles == 0);
        to1 = bus.timeout;
      end
      if (bus.imem_wr_en != (bus.in_valid && bus.in_ready)) wr_bad++;
      if (bus.in_valid && bus.in_ready) begin
        if (int'(bus.imem_wr_addr) != widx % DEPTH || bus.imem_wr_data != bus.in_data) wr_bad++;
        imem_m[bus.imem_wr_addr] = bus.imem_wr_data;
        if (first_wr < 0) first_wr = k;
        last_wr = k;
        widx++;
      end
      if (bus.k_start) begin
        ks_cnt++;
        if (ks_iter < 0) ks_iter = k;
      end
      if (bus.kernel_owns_mem) own_cnt++;
      else if (ks_iter >= 0 && own_fall < 0) own_fall = k;
      if (bus.omem_rd_en) begin
        if (first_rd < 0) first_rd = k;
        if (int'(bus.omem_rd_addr) != rd_idx % DEPTH) rd_bad++;
        rd_idx++;
      end
      pend_rd = bus.omem_rd_en;
      pend_addr = bus.omem_rd_addr;
      if (bus.out_valid && first_ov < 0) first_ov = k;
      if (prev_stall && (!bus.out_valid || bus.out_data != prev_data)) stab_bad++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (pops >= L || bus.out_data != omem_m[pops % DEPTH]) pop_bad++;
        pops++;
        if (first_pop < 0) first_pop = k;
        last_pop = k;
      end
      if (k > 0 && !bus.busy) begin
        busy_fall = k;
        break;
      end
    end
    bus.go = 0; bus.in_valid = 0; bus.out_ready = 0; bus.k_done = 0;
    chk("run_terminates", busy_fall >= 0, 1);
    chk("in_ready_after_go", ir1, 1);
    chk("cycles_cleared_by_go", cyc1_zero, 1);
    chk("timeout_cleared_by_go", to1, 0);
    chk("wr_port_errors", wr_bad, 0);
    chk("words_loaded", widx, L);
    img_bad = 0;
    for (int i = 0; i < L; i++) if (imem_m[i % DEPTH] !== words[i]) img_bad++;
    chk("imem_image", img_bad, 0);
    if (vm == 0) chk("load_throughput", last_wr - first_wr, L - 1);
    chk("wr_addr_end", bus.imem_wr_addr, L % DEPTH);
    chk("k_start_pulses", ks_cnt, 1);
    chk("k_start_latency", ks_iter, last_wr + 1);
    chk("owns_mem_cycles", own_cnt, exp_cyc);
    chk("owns_mem_fall", own_fall, ks_iter + exp_cyc);
    chk("first_rd_en", first_rd, own_fall);
    chk("first_out_valid", first_ov, own_fall + 1);
    chk("rd_addr_errors", rd_bad, 0);
    chk("reads_issued", rd_idx, L);
    chk("words_drained", pops, L);
    chk("drain_data_errors", pop_bad, 0);
    chk("stall_stability", stab_bad, 0);
    if (rm == 0) chk("drain_throughput", last_pop - first_pop, L - 1);
    chk("done_to_idle", busy_fall, last_pop + 2);
    chk("cycles", bus.cycles, exp_cyc);
    chk("timeout", bus.timeout, exp_to);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_k_start"}, bus.k_start, 0);
    chk({tag, "_owns_mem"}, bus.kernel_owns_mem, 0);
    chk({tag, "_imem_wr_en"}, bus.imem_wr_en, 0);
    chk({tag, "_omem_rd_en"}, bus.omem_rd_en, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
    chk({tag, "_cycles"}, bus.cycles, 0);
    chk({tag, "_wr_addr"}, bus.imem_wr_addr, 0);
    chk({tag, "_rd_addr"}, bus.omem_rd_addr, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kd, ln, spur;
    tbl[0] = '{len: 4, kd: 10, vm: 0, rm: 1, exp_cyc: 11, exp_to: 0};
    tbl[1] = '{len: 4, kd: -1, vm: 0, rm: 0, exp_cyc: 16, exp_to: 1};
    tbl[2] = '{len: 1, kd: 1,  vm: 1, rm: 2, exp_cyc: 2,  exp_to: 0};
    tbl[3] = '{len: 3, kd: 15, vm: 0, rm: 0, exp_cyc: 16, exp_to: 0};
    tbl[4] = '{len: 2, kd: 16, vm: 1, rm: 1, exp_cyc: 16, exp_to: 1};
    tbl[5] = '{len: 8, kd: 5,  vm: 1, rm: 2, exp_cyc: 6,  exp_to: 0};

    bus.go = 0; bus.len = '0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus.k_done = 0; bus.omem_rd_data = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk); #1;
    check_reset_outputs("reset");

    for (int i = 0; i < 6; i++)
      run(tbl[i].len, tbl[i].kd, tbl[i].vm, tbl[i].rm, tbl[i].exp_cyc, tbl[i].exp_to, 1'b1, 1'b0);

    // reset mid-load after two of four words
    @(negedge clk);
    bus.go = 1; bus.len = 11'd4;
    @(negedge clk);
    bus.go = 0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1; bus.in_data = 32'h100 + i;
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check_reset_outputs("mid_load_rst");
    spur = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (bus.k_start || bus.busy || bus.imem_wr_en) spur++;
    end
    chk("idle_after_rst", spur, 0);
    bus.in_valid = 0;
    run(4, 10, 0, 0, 11, 0, 1'b0, 1'b0);

    // len=0 means full depth; stray go during LOAD and RUN
    run(0, -1, 0, 0, TO, 1, 1'b0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      ln = $urandom_range(1, 40);
      kd = $urandom_range(1, 24);
      if (kd > 20) kd = -1;
      run(ln, kd, $urandom_range(0, 1), $urandom_range(0, 2),
          model_cycles(kd), model_to(kd), 1'b0, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
